// File: rtl/dc_pwm_ramp_multi.sv
// Multi-channel DC motor PWM driver: shared period counter, per-channel level
// ramping with reversal-through-zero, level-sensitive brake and glitch-free duty latch.
//   state     | meaning
//   HOLD      | cur_level equals target, dir_out equals dir
//   RAMP_UP   | stepping cur_level up toward target
//   RAMP_DOWN | stepping cur_level down toward target
//   REVERSE   | ramping to 0 before dir_out flips
//   BRAKE     | forced stop, waits for brake release and a period boundary
module dc_pwm_ramp_multi #(
  parameter int CLK_FREQ   = 100_000_000,
  parameter int PWM_FREQ   = 20_000,
  parameter int NUM_CH     = 2,
  parameter int LEVEL_W    = 4,
  parameter int MAX_LEVEL  = 15,
  parameter int RAMP_TICKS = 200
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        enable,
  input  logic [NUM_CH*LEVEL_W-1:0]   speed_level,
  input  logic [NUM_CH-1:0]           dir,
  input  logic [NUM_CH-1:0]           brake,
  output logic [NUM_CH-1:0]           pwm_out,
  output logic [NUM_CH-1:0]           dir_out,
  output logic [NUM_CH*LEVEL_W-1:0]   cur_level,
  output logic [NUM_CH-1:0]           at_target,
  output logic                        period_start
);

  localparam int PERIOD = CLK_FREQ / PWM_FREQ;
  localparam int CNT_W  = (PERIOD > 1) ? $clog2(PERIOD) : 1;
  localparam int DUTY_W = $clog2(PERIOD + 1);
  localparam int TICK_W = $clog2(RAMP_TICKS + 1);
  localparam logic [LEVEL_W-1:0] MAX_L = LEVEL_W'(MAX_LEVEL);

  typedef enum logic [2:0] {
    HOLD      = 3'd0,
    RAMP_UP   = 3'd1,
    RAMP_DOWN = 3'd2,
    REVERSE   = 3'd3,
    BRAKE     = 3'd4
  } state_t;

  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               period_start_q, period_start_d;
  logic               boundary;

  state_t              state_q [NUM_CH];
  state_t              state_d [NUM_CH];
  logic [LEVEL_W-1:0]  cur_q   [NUM_CH];
  logic [LEVEL_W-1:0]  cur_d   [NUM_CH];
  logic [TICK_W-1:0]   tick_q  [NUM_CH];
  logic [TICK_W-1:0]   tick_d  [NUM_CH];
  logic [DUTY_W-1:0]   duty_q  [NUM_CH];
  logic [DUTY_W-1:0]   duty_d  [NUM_CH];
  logic [NUM_CH-1:0]   dir_out_q, dir_out_d;
  logic [NUM_CH-1:0]   pwm_q, pwm_d;
  logic [LEVEL_W-1:0]  tgt     [NUM_CH];

  // 64-bit intermediate keeps level*PERIOD exact for large clock ratios
  function automatic logic [DUTY_W-1:0] duty_of(input logic [LEVEL_W-1:0] lvl);
    logic [63:0] prod;
    prod = (64'(lvl) * 64'(PERIOD)) / 64'(MAX_LEVEL);
    return DUTY_W'(prod);
  endfunction

  always_comb begin
    boundary       = (cnt_q == CNT_W'(PERIOD - 1));
    cnt_d          = boundary ? '0 : cnt_q + CNT_W'(1);
    period_start_d = (cnt_d == '0);
  end

  always_comb begin
    logic [LEVEL_W-1:0] spd;
    spd = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      spd          = speed_level[i*LEVEL_W +: LEVEL_W];
      tgt[i]       = !enable ? '0 : ((spd > MAX_L) ? MAX_L : spd);
      at_target[i] = (cur_q[i] == tgt[i]) && (dir_out_q[i] == dir[i]);
    end
  end

  always_comb begin
    logic [TICK_W-1:0] tick_nx;
    logic              step;
    state_d   = state_q;
    cur_d     = cur_q;
    tick_d    = tick_q;
    duty_d    = duty_q;
    dir_out_d = dir_out_q;
    pwm_d     = '0;
    tick_nx   = '0;
    step      = 1'b0;
    for (int i = 0; i < NUM_CH; i++) begin
      tick_nx  = tick_q[i] + TICK_W'(1);
      step     = (tick_nx == TICK_W'(RAMP_TICKS));
      pwm_d[i] = (state_q[i] != BRAKE) && (DUTY_W'(cnt_q) < duty_q[i]);
      if (brake[i]) begin
        state_d[i] = BRAKE;
        cur_d[i]   = '0;
        tick_d[i]  = '0;
        duty_d[i]  = '0;
        pwm_d[i]   = 1'b0;
      end else if (boundary) begin
        if (dir[i] != dir_out_q[i]) begin
          if (cur_q[i] == '0) begin
            dir_out_d[i] = dir[i];
            tick_d[i]    = '0;
            state_d[i]   = (tgt[i] == '0) ? HOLD : RAMP_UP;
          end else begin
            state_d[i] = REVERSE;
            tick_d[i]  = step ? '0 : tick_nx;
            cur_d[i]   = step ? cur_q[i] - LEVEL_W'(1) : cur_q[i];
          end
        end else if (cur_q[i] == tgt[i]) begin
          state_d[i] = HOLD;
          tick_d[i]  = '0;
        end else if (cur_q[i] < tgt[i]) begin
          state_d[i] = RAMP_UP;
          tick_d[i]  = step ? '0 : tick_nx;
          cur_d[i]   = step ? cur_q[i] + LEVEL_W'(1) : cur_q[i];
        end else begin
          state_d[i] = RAMP_DOWN;
          tick_d[i]  = step ? '0 : tick_nx;
          cur_d[i]   = step ? cur_q[i] - LEVEL_W'(1) : cur_q[i];
        end
        // latch the post-step level so the new duty applies from the next period
        duty_d[i] = duty_of(cur_d[i]);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q          <= '0;
      period_start_q <= 1'b0;
      dir_out_q      <= '1;
      pwm_q          <= '0;
      for (int i = 0; i < NUM_CH; i++) begin
        state_q[i] <= HOLD;
        cur_q[i]   <= '0;
        tick_q[i]  <= '0;
        duty_q[i]  <= '0;
      end
    end else begin
      cnt_q          <= cnt_d;
      period_start_q <= period_start_d;
      dir_out_q      <= dir_out_d;
      pwm_q          <= pwm_d;
      for (int i = 0; i < NUM_CH; i++) begin
        state_q[i] <= state_d[i];
        cur_q[i]   <= cur_d[i];
        tick_q[i]  <= tick_d[i];
        duty_q[i]  <= duty_d[i];
      end
    end
  end

  always_comb begin
    cur_level = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      cur_level[i*LEVEL_W +: LEVEL_W] = cur_q[i];
    end
  end

  assign pwm_out      = pwm_q;
  assign dir_out      = dir_out_q;
  assign period_start = period_start_q;

endmodule

// File: tb/tb_dc_pwm_ramp_multi.sv
// Scoreboard bench for dc_pwm_ramp_multi with PERIOD=10, MAX_LEVEL=10, RAMP_TICKS=2.
// Expectations are queued by the stimulus; the monitor pops them at period_start (or next cycle).
module tb_dc_pwm_ramp_multi;

  logic       clk;
  logic       rst;
  logic       enable;
  logic [7:0] speed_level;
  logic [1:0] dir;
  logic [1:0] brake;
  logic [1:0] pwm_out;
  logic [1:0] dir_out;
  logic [7:0] cur_level;
  logic [1:0] at_target;
  logic       period_start;

  dc_pwm_ramp_multi #(
    .CLK_FREQ(1000), .PWM_FREQ(100), .NUM_CH(2), .LEVEL_W(4),
    .MAX_LEVEL(10), .RAMP_TICKS(2)
  ) dut (
    .clk(clk), .rst(rst), .enable(enable), .speed_level(speed_level),
    .dir(dir), .brake(brake), .pwm_out(pwm_out), .dir_out(dir_out),
    .cur_level(cur_level), .at_target(at_target), .period_start(period_start)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string      name;
    bit         imm;
    logic [7:0] cur;
    logic [1:0] dout;
    logic [1:0] att;
    logic [1:0] pwm;
    logic       ps;
    bit         chk_hi;
    int         hi0;
    int         hi1;
    bit         chk_cyc;
    int         cyc;
  } exp_t;

  exp_t q[$];
  int   tests = 0;
  int   fails = 0;

  task automatic push(input string nm, input bit imm, input int c0, input int c1,
                      input logic [1:0] dout, input logic [1:0] att, input logic [1:0] pwm,
                      input logic ps, input bit chk_hi, input int h0, input int h1,
                      input bit chk_cyc, input int cyc);
    exp_t e;
    e.name = nm; e.imm = imm; e.cur = {4'(c1), 4'(c0)}; e.dout = dout; e.att = att;
    e.pwm = pwm; e.ps = ps; e.chk_hi = chk_hi; e.hi0 = h0; e.hi1 = h1;
    e.chk_cyc = chk_cyc; e.cyc = cyc;
    q.push_back(e);
  endtask

  task automatic push_p(input string nm, input int c0, input int c1, input logic [1:0] dout,
                        input logic [1:0] att, input bit chk_hi, input int h0, input int h1);
    push(nm, 1'b0, c0, c1, dout, att, 2'b00, 1'b0, chk_hi, h0, h1, 1'b0, 0);
  endtask

  task automatic sync_ps();
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (period_start !== 1'b1 && n < 40);
    if (period_start !== 1'b1) begin
      tests++; fails++;
      $display("FAIL sync_ps: period_start not seen within %0d cycles", n);
    end
    #1;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (q.size() > 0 && n < 400) begin
      @(negedge clk);
      n++;
    end
    if (q.size() > 0) begin
      tests++; fails++;
      $display("FAIL drain: %0d expectations left unconsumed, required 0", q.size());
      q.delete();
    end
  endtask

  // monitor
  initial begin
    exp_t e;
    int   w0, w1, hi0_cnt, hi1_cnt, since_rst;
    bit   bad;
    hi0_cnt = 0; hi1_cnt = 0; since_rst = 0;
    forever begin
      @(negedge clk);
      w0 = hi0_cnt; w1 = hi1_cnt;
      if (period_start === 1'b1) begin
        hi0_cnt = int'(pwm_out[0]); hi1_cnt = int'(pwm_out[1]);
      end else begin
        hi0_cnt += int'(pwm_out[0]); hi1_cnt += int'(pwm_out[1]);
      end
      since_rst = (rst === 1'b1) ? 0 : since_rst + 1;
      if (q.size() > 0 && (q[0].imm || period_start === 1'b1)) begin
        e = q.pop_front();
        tests++;
        bad = (cur_level !== e.cur) || (dir_out !== e.dout) || (at_target !== e.att);
        if (e.imm && ((pwm_out !== e.pwm) || (period_start !== e.ps))) bad = 1'b1;
        if (e.chk_hi && ((w0 != e.hi0) || (w1 != e.hi1))) bad = 1'b1;
        if (e.chk_cyc && (since_rst != e.cyc)) bad = 1'b1;
        if (bad) begin
          fails++;
          $display("FAIL %s: got cur=%h dout=%b att=%b pwm=%b ps=%b hi=%0d,%0d cyc=%0d; want cur=%h dout=%b att=%b pwm=%b ps=%b hi=%0d,%0d cyc=%0d",
                   e.name, cur_level, dir_out, at_target, pwm_out, period_start, w0, w1, since_rst,
                   e.cur, e.dout, e.att, e.pwm, e.ps, e.hi0, e.hi1, e.cyc);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  // stimulus
  initial begin
    int c0, c1;
    int rev_c1 [14] = '{3, 2, 2, 1, 1, 0, 0, 0, 1, 1, 2, 2, 3, 3};
    int dn_c0  [7]  = '{1, 1, 0, 0, 0, 0, 0};
    int dn_c1  [7]  = '{3, 2, 2, 1, 1, 0, 0};
    rst = 1'b1; enable = 1'b1; speed_level = {4'd0, 4'd4}; dir = 2'b11; brake = 2'b00;
    repeat (3) @(posedge clk);
    #1;
    push("reset", 1'b1, 0, 0, 2'b11, 2'b10, 2'b00, 1'b0, 1'b0, 0, 0, 1'b0, 0);
    @(negedge clk);
    #1;
    rst = 1'b0;
    push("rst_exit", 1'b1, 0, 0, 2'b11, 2'b10, 2'b00, 1'b0, 1'b0, 0, 0, 1'b0, 0);
    for (int j = 1; j <= 10; j++) begin
      c0 = (j / 2 > 4) ? 4 : j / 2;
      push("ramp_up", 1'b0, c0, 0, 2'b11, {1'b1, c0 == 4}, 2'b00, 1'b0,
           j == 10, 4, 0, j == 1, 10);
    end

    drain(); sync_ps();
    speed_level = {4'd0, 4'd15};
    for (int j = 1; j <= 14; j++) begin
      c0 = (4 + j / 2 > 10) ? 10 : 4 + j / 2;
      push_p("clamp_up", c0, 0, 2'b11, {1'b1, c0 == 10}, j == 14, 10, 0);
    end

    drain(); sync_ps();
    speed_level = {4'd0, 4'd0};
    for (int j = 1; j <= 22; j++) begin
      c0 = (10 - j / 2 < 0) ? 0 : 10 - j / 2;
      push_p("ramp_to_zero", c0, 0, 2'b11, {1'b1, c0 == 0}, j == 22, 0, 0);
    end

    drain(); sync_ps();
    speed_level = {4'd3, 4'd0};
    for (int j = 1; j <= 8; j++) begin
      c1 = (j / 2 > 3) ? 3 : j / 2;
      push_p("ch1_up", 0, c1, 2'b11, {c1 == 3, 1'b1}, j == 8, 0, 3);
    end

    drain(); sync_ps();
    dir = 2'b01;
    for (int j = 1; j <= 14; j++) begin
      push_p("reverse", 0, rev_c1[j-1], {j < 7, 1'b1}, {(rev_c1[j-1] == 3) && (j >= 7), 1'b1},
             (j == 7) || (j == 8) || (j == 14), 0, (j == 14) ? 3 : 0);
    end

    drain(); sync_ps();
    speed_level = {4'd3, 4'd6};
    for (int j = 1; j <= 14; j++) begin
      c0 = (j / 2 > 6) ? 6 : j / 2;
      push_p("ch0_up6", c0, 3, 2'b01, {1'b1, c0 == 6}, j == 14, 6, 3);
    end

    drain(); sync_ps();
    @(negedge clk);
    #1;
    brake = 2'b01;
    push("brake", 1'b1, 0, 3, 2'b01, 2'b10, 2'b10, 1'b0, 1'b0, 0, 0, 1'b0, 0);
    sync_ps();
    push_p("braked", 0, 3, 2'b01, 2'b10, 1'b1, 0, 3);
    sync_ps();
    brake = 2'b00;
    for (int j = 1; j <= 4; j++) begin
      push_p("release", j / 2, 3, 2'b01, 2'b10, 1'b0, 0, 0);
    end

    drain(); sync_ps();
    enable = 1'b0;
    for (int j = 1; j <= 7; j++) begin
      push_p("enable_drop", dn_c0[j-1], dn_c1[j-1], 2'b01,
             {dn_c1[j-1] == 0, dn_c0[j-1] == 0}, j == 7, 0, 0);
    end

    drain(); sync_ps();
    enable = 1'b1;
    repeat (3) sync_ps();
    repeat (3) @(negedge clk);
    #1;
    rst = 1'b1;
    push("rst_mid", 1'b1, 0, 0, 2'b11, 2'b00, 2'b00, 1'b0, 1'b0, 0, 0, 1'b0, 0);
    @(negedge clk);
    #1;
    rst = 1'b0;
    push("rst_exit2", 1'b1, 0, 0, 2'b11, 2'b00, 2'b00, 1'b0, 1'b0, 0, 0, 1'b0, 0);
    push("restart", 1'b0, 0, 0, 2'b01, 2'b00, 2'b00, 1'b0, 1'b0, 0, 0, 1'b1, 10);
    drain();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/dc_pwm_ramp_multi.md
DC_PWM_RAMP_MULTI -- requirements
Module: dc_pwm_ramp_multi

Interface
REQ-001 SHALL have parameter CLK_FREQ, default 100_000_000, input clock frequency in Hz.
REQ-002 SHALL have parameter PWM_FREQ, default 20_000, PWM carrier frequency in Hz; PERIOD = CLK_FREQ/PWM_FREQ (integer floor, >=2).
REQ-003 SHALL have parameter NUM_CH, default 2, number of independent motor channels (>=1).
REQ-004 SHALL have parameter LEVEL_W, default 4, width of one speed level.
REQ-005 SHALL have parameter MAX_LEVEL, default 15, full-scale level (1..2^LEVEL_W-1).
REQ-006 SHALL have parameter RAMP_TICKS, default 200, PWM periods per one-level ramp step (>=1).
REQ-007 SHALL have port clk  input  1  sole clock, all logic on rising edge.
REQ-008 SHALL have port rst  input  1  synchronous reset, active-high.
REQ-009 SHALL have port enable  input  1  global run enable; 0 forces every channel's target to 0 (ramped, not braked).
REQ-010 SHALL have port speed_level  input  NUM_CH*LEVEL_W  target level per channel, channel i at bits [i*LEVEL_W +: LEVEL_W].
REQ-011 SHALL have port dir  input  NUM_CH  requested direction per channel (1 = forward).
REQ-012 SHALL have port brake  input  NUM_CH  per-channel emergency stop, level-sensitive.
REQ-013 SHALL have port pwm_out  output  NUM_CH  registered PWM per channel.
REQ-014 SHALL have port dir_out  output  NUM_CH  applied direction per channel.
REQ-015 SHALL have port cur_level  output  NUM_CH*LEVEL_W  ramped level currently applied per channel.
REQ-016 SHALL have port at_target  output  NUM_CH  1 when channel's cur_level equals effective target and dir_out equals dir.
REQ-017 SHALL have port period_start  output  1  one-cycle pulse while period counter is 0.

Function
REQ-018 SHALL run one shared period counter 0..PERIOD-1, incrementing every clock, wrapping PERIOD-1 -> 0.
REQ-019 Effective target SHALL be min(speed_level_i, MAX_LEVEL), forced to 0 when enable=0.
REQ-020 Per channel duty SHALL be floor(cur_level_i*PERIOD/MAX_LEVEL), computed with >=32-bit intermediate, latched only when counter = PERIOD-1 (glitch-free; mid-period changes take effect next period).
REQ-021 pwm_out_i SHALL be registered: pwm_out_i <= (counter < duty_latched_i); level 0 -> constantly 0, MAX_LEVEL -> constantly 1.
REQ-022 Each channel SHALL run an FSM: HOLD (cur=target, dir_out=dir), RAMP_UP, RAMP_DOWN, REVERSE (ramp to 0 before flip), BRAKE.
REQ-023 Ramp steps SHALL occur only at period boundaries (counter = PERIOD-1); per-channel tick counter counts boundaries, steps cur_level by exactly 1 toward its goal every RAMP_TICKS boundaries, and resets to 0 on every step and on entry to HOLD.
REQ-024 When dir != dir_out and cur_level > 0, channel SHALL enter REVERSE, ramp down to 0, then toggle dir_out at the boundary where cur_level becomes 0 is observed, then ramp up in the new direction.
REQ-025 When dir != dir_out and cur_level = 0, dir_out SHALL update at the next period boundary.
REQ-026 brake_i=1 SHALL, on the next clock, set cur_level_i=0, duty_latched_i=0, pwm_out_i=0, tick counter 0, state BRAKE; dir_out_i held.
REQ-027 On brake_i deassert, channel SHALL leave BRAKE to HOLD/RAMP_UP/REVERSE at the next period boundary and ramp from 0.
REQ-028 Target changes during a ramp SHALL retarget without resetting the tick counter; reversing ramp direction is allowed mid-ramp.
REQ-029 Channels SHALL be fully independent except for the shared counter and enable.

Reset
REQ-030 On rst=1 at a clock edge: counter=0, all cur_level=0, duty_latched=0, pwm_out=0, dir_out=all 1 (forward), tick counters=0, states HOLD, at_target recomputed from inputs, period_start=0 the cycle after reset exits, then 1 when counter=0.
REQ-031 rst mid-period or mid-ramp SHALL abort immediately with REQ-030 values; no partial pulse after the reset edge.

Verification (CLK_FREQ=1000, PWM_FREQ=100 -> PERIOD=10, MAX_LEVEL=10, LEVEL_W=4, RAMP_TICKS=2, NUM_CH=2)
REQ-032 Ramp up: ch0 target 4 from 0, enable=1 -> cur_level 1,2,3,4 at every 2nd boundary; final pwm_out high 4 of 10 cycles; at_target=1.
REQ-033 Clamp/extremes: target 15 -> cur_level stops at 10, pwm_out constantly 1; target 0 -> ramps down to constant 0.
REQ-034 Reversal: ch1 at level 3 forward, dir=0 -> ramps 3->0, dir_out flips to 0 only after level 0, ramps back to 3; pwm_out never high while dir_out changes.
REQ-035 Brake: ch0 at level 6, brake=1 mid-period -> next cycle pwm_out=0, cur_level=0; ch1 unaffected; release -> ramp from 0 at 2-period steps.
REQ-036 Enable drop and reset: enable=0 -> both channels ramp to 0; rst asserted mid-ramp -> all outputs at REQ-030 values next cycle, counter restarts at 0.
